// File: rtl/parking_gate_arbiter_if.sv
// Lane-request / gate-command bundle between the lane controllers and the gate arbiter.
interface parking_gate_arbiter_if #(
  parameter int CNT_W = 4
) ();
  logic             req_in;
  logic             req_out;
  logic             car_passed;
  logic             alm_ack;
  logic             grant_in;
  logic             grant_out;
  logic             gate_o;
  logic             gate_cls;
  logic             alm_timeout;
  logic             lot_full;
  logic [CNT_W-1:0] occupancy;

  modport master (
    output req_in, req_out, car_passed, alm_ack,
    input  grant_in, grant_out, gate_o, gate_cls, alm_timeout, lot_full, occupancy
  );

  modport slave (
    input  req_in, req_out, car_passed, alm_ack,
    output grant_in, grant_out, gate_o, gate_cls, alm_timeout, lot_full, occupancy
  );
endinterface

// File: rtl/parking_gate_arbiter.sv
// Shares one parking gate between entry and exit lanes, tracks occupancy and
// raises an alarm when a granted vehicle fails to clear the gate in time.
module parking_gate_arbiter #(
  parameter int CAPACITY     = 8,
  parameter int CNT_W        = 4,
  parameter int OPEN_TIMEOUT = 16,
  parameter int TMR_W        = 5
) (
  input logic                   clock,
  input logic                   reset,
  parking_gate_arbiter_if.slave bus
);

  typedef enum logic [4:0] {
    S_IDLE      = 5'b00001,
    S_GRANT_IN  = 5'b00010,
    S_GRANT_OUT = 5'b00100,
    S_CLOSING   = 5'b01000,
    S_ALARM     = 5'b10000
  } state_t;

  localparam logic [CNT_W-1:0] CAP       = CNT_W'(CAPACITY);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(OPEN_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             last_out_q, last_out_d;  // 1: exit lane held the most recent grant
  logic             in_ok, out_ok;

  always_comb begin
    state_d    = state_q;
    occ_d      = occ_q;
    timer_d    = timer_q;
    last_out_d = last_out_q;
    in_ok      = bus.req_in & (occ_q < CAP);
    out_ok     = bus.req_out & (occ_q != '0);

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        // On a tie the lane that did not hold the last grant wins.
        if (in_ok && (!out_ok || last_out_q)) begin
          state_d    = S_GRANT_IN;
          last_out_d = 1'b0;
        end else if (out_ok) begin
          state_d    = S_GRANT_OUT;
          last_out_d = 1'b1;
        end
      end
      S_GRANT_IN: begin
        if (bus.car_passed) begin
          state_d = S_CLOSING;
          if (occ_q != CAP) occ_d = occ_q + CNT_W'(1);
        end else if (timer_q == TMR_LAST) begin
          state_d = S_ALARM;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_GRANT_OUT: begin
        if (bus.car_passed) begin
          state_d = S_CLOSING;
          if (occ_q != '0) occ_d = occ_q - CNT_W'(1);
        end else if (timer_q == TMR_LAST) begin
          state_d = S_ALARM;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_CLOSING: begin
        state_d = S_IDLE;
      end
      S_ALARM: begin
        if (bus.alm_ack) state_d = S_CLOSING;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      occ_q      <= '0;
      timer_q    <= '0;
      last_out_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      timer_q    <= timer_d;
      last_out_q <= last_out_d;
    end
  end

  // Exact-match decode keeps every output low for an illegal encoding.
  assign bus.grant_in    = (state_q == S_GRANT_IN);
  assign bus.grant_out   = (state_q == S_GRANT_OUT);
  assign bus.alm_timeout = (state_q == S_ALARM);
  assign bus.gate_cls    = (state_q == S_CLOSING);
  assign bus.gate_o      = (state_q == S_GRANT_IN) | (state_q == S_GRANT_OUT) |
                           (state_q == S_ALARM);
  assign bus.lot_full    = (occ_q == CAP);
  assign bus.occupancy   = occ_q;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Directed bench for parking_gate_arbiter: a lane-level model is compared every
// cycle, and literal expectations pin the key scenario results.
module tb_parking_gate_arbiter;
  localparam int CAP  = 8;
  localparam int TOUT = 16;

  logic clock = 1'b0;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;

  parking_gate_arbiter_if #(.CNT_W(4)) bus ();

  parking_gate_arbiter #(
    .CAPACITY(CAP), .CNT_W(4), .OPEN_TIMEOUT(TOUT), .TMR_W(5)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Lane-level model: which lane owns the gate, whether the alarm is up,
  // whether a close pulse is due, and how long the gate has been open.
  bit m_valid   = 0;
  int m_occ     = 0;
  int m_lane    = 0;   // 0 none, 1 entry, 2 exit
  int m_last    = 2;
  int m_open    = 0;
  bit m_alarm   = 0;
  bit m_closing = 0;

  initial begin
    forever begin
      @(negedge clock);
      if (m_valid) begin
        check("grant_in",    bus.grant_in,    32'(m_lane == 1));
        check("grant_out",   bus.grant_out,   32'(m_lane == 2));
        check("gate_o",      bus.gate_o,      32'((m_lane != 0) || m_alarm));
        check("gate_cls",    bus.gate_cls,    32'(m_closing));
        check("alm_timeout", bus.alm_timeout, 32'(m_alarm));
        check("lot_full",    bus.lot_full,    32'(m_occ == CAP));
        check("occupancy",   bus.occupancy,   32'(m_occ));
      end
      if (reset) begin
        m_valid = 1; m_occ = 0; m_lane = 0; m_last = 2;
        m_open = 0; m_alarm = 0; m_closing = 0;
      end else if (m_closing) begin
        m_closing = 0;
      end else if (m_alarm) begin
        if (bus.alm_ack) begin
          m_alarm = 0; m_closing = 1;
        end
      end else if (m_lane != 0) begin
        if (bus.car_passed) begin
          if (m_lane == 1) m_occ = (m_occ < CAP) ? m_occ + 1 : CAP;
          else             m_occ = (m_occ > 0) ? m_occ - 1 : 0;
          m_lane = 0; m_closing = 1;
        end else if (m_open == TOUT - 1) begin
          m_lane = 0; m_alarm = 1;
        end else begin
          m_open++;
        end
      end else begin
        bit in_ok, out_ok;
        in_ok  = bus.req_in  && (m_occ < CAP);
        out_ok = bus.req_out && (m_occ > 0);
        if (in_ok && out_ok) m_lane = (m_last == 1) ? 2 : 1;
        else if (in_ok)      m_lane = 1;
        else if (out_ok)     m_lane = 2;
        if (m_lane != 0) begin
          m_last = m_lane; m_open = 0;
        end
      end
    end
  end

  task automatic do_entry();
    bus.req_in = 1; tick(1);
    bus.req_in = 0; tick(2);
    bus.car_passed = 1; tick(1);
    bus.car_passed = 0; tick(1);
  endtask

  task automatic do_exit();
    bus.req_out = 1; tick(1);
    bus.req_out = 0; tick(2);
    bus.car_passed = 1; tick(1);
    bus.car_passed = 0; tick(1);
  endtask

  initial begin
    int n;
    int exp_occ[3] = '{4, 3, 4};
    reset = 1;
    bus.req_in = 0; bus.req_out = 0; bus.car_passed = 0; bus.alm_ack = 0;
    tick(2);
    reset = 0;
    check("reset_occ", bus.occupancy, 0);
    check("reset_gate", bus.gate_o, 0);
    check("reset_alarm", bus.alm_timeout, 0);

    // Single entry, one-cycle grant latency, request dropped while granted.
    bus.req_in = 1; tick(1);
    check("entry_grant", bus.grant_in, 1);
    check("entry_gate", bus.gate_o, 1);
    bus.req_in = 0; tick(3);
    check("entry_hold", bus.grant_in, 1);
    bus.car_passed = 1; tick(1);
    bus.car_passed = 0;
    check("entry_cls", bus.gate_cls, 1);
    check("entry_occ", bus.occupancy, 1);
    tick(1);
    check("entry_idle_cls", bus.gate_cls, 0);

    // Reach occupancy 3 with the exit lane holding the last grant.
    do_entry(); do_entry(); do_entry(); do_exit();
    check("pre_tie_occ", bus.occupancy, 3);

    // Tie: both lanes held, grants alternate IN, OUT, IN.
    bus.req_in = 1; bus.req_out = 1;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (!(bus.grant_in || bus.grant_out) && n < 6) begin tick(1); n++; end
      check("tie_lane_in", bus.grant_in, 32'(i != 1));
      check("tie_lane_out", bus.grant_out, 32'(i == 1));
      bus.car_passed = 1; tick(1);
      bus.car_passed = 0;
      if (i == 2) begin bus.req_in = 0; bus.req_out = 0; end
      check("tie_occ", bus.occupancy, 32'(exp_occ[i]));
      tick(1);
    end

    // Full lot: entry refused, exit served, then entry granted again.
    do_entry(); do_entry(); do_entry(); do_entry();
    check("full_flag", bus.lot_full, 1);
    check("full_occ", bus.occupancy, 8);
    bus.req_in = 1; tick(5);
    check("full_refuse", bus.grant_in, 0);
    bus.req_out = 1; tick(1);
    check("full_exit_grant", bus.grant_out, 1);
    bus.req_out = 0; tick(1);
    bus.car_passed = 1; tick(1);
    bus.car_passed = 0;
    check("full_exit_occ", bus.occupancy, 7);
    check("full_exit_flag", bus.lot_full, 0);
    tick(2);
    check("full_reentry", bus.grant_in, 1);
    bus.req_in = 0; tick(1);
    bus.car_passed = 1; tick(1);
    bus.car_passed = 0; tick(1);
    do_exit();

    // Timeout: alarm exactly OPEN_TIMEOUT cycles after grant, gate held open.
    bus.req_in = 1; tick(1);
    bus.req_in = 0;
    check("to_grant", bus.grant_in, 1);
    n = 0;
    while (!bus.alm_timeout && n < 40) begin tick(1); n++; end
    check("to_latency", n, TOUT);
    check("to_gate", bus.gate_o, 1);
    bus.car_passed = 1; tick(1);
    bus.car_passed = 0;
    check("to_car_ignored_occ", bus.occupancy, 7);
    check("to_car_ignored_alm", bus.alm_timeout, 1);
    bus.alm_ack = 1; tick(1);
    bus.alm_ack = 0;
    check("to_ack_cls", bus.gate_cls, 1);
    check("to_ack_alm", bus.alm_timeout, 0);
    check("to_ack_occ", bus.occupancy, 7);
    tick(1);
    bus.car_passed = 1; tick(1);
    bus.car_passed = 0;
    check("idle_car_ignored", bus.occupancy, 7);

    // Reset during GRANT_OUT with occupancy 5, car_passed on the same edge.
    do_exit(); do_exit();
    bus.req_out = 1; tick(1);
    bus.req_out = 0;
    check("rst_pre_grant", bus.grant_out, 1);
    check("rst_pre_occ", bus.occupancy, 5);
    tick(2);
    reset = 1; bus.car_passed = 1; tick(1);
    reset = 0; bus.car_passed = 0;
    check("rst_occ", bus.occupancy, 0);
    check("rst_gate", bus.gate_o, 0);
    check("rst_grant", bus.grant_out, 0);

    // Empty lot: exit request never granted.
    bus.req_out = 1; tick(20);
    check("empty_grant", bus.grant_out, 0);
    check("empty_gate", bus.gate_o, 0);
    bus.req_out = 0; tick(1);

    // car_passed on the last open cycle beats the timeout.
    bus.req_in = 1; tick(1);
    bus.req_in = 0; tick(TOUT - 1);
    bus.car_passed = 1; tick(1);
    bus.car_passed = 0;
    check("edge_cls", bus.gate_cls, 1);
    check("edge_alm", bus.alm_timeout, 0);
    check("edge_occ", bus.occupancy, 1);
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
